// File: rtl/ram16x2_seq_pkg.sv
// -----------------------------------------------------------------------------
// ram16x2_seq_pkg
//   Shared types and sizes for the 16x2 distributed-RAM write/read sequencer.
//   - ADDR_W / DATA_W / DEPTH : slice geometry
//   - state_e                 : sequencer FSM states (CLEAR sweep, RUN)
//   - gnt_e                   : round-robin pointer (which port wins a tie)
//   - ram_req_t               : registered RAM-side pin bundle (AD, M, WE)
// -----------------------------------------------------------------------------
package ram16x2_seq_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 2;
    localparam int DEPTH  = 16;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } gnt_e;

    typedef struct packed {
        logic [ADDR_W-1:0] ad;
        logic [DATA_W-1:0] m;
        logic              we;
    } ram_req_t;

    // Hand the tie-break priority to the other port.
    function automatic gnt_e gnt_flip(input gnt_e g);
        return (g == GNT_WR) ? GNT_RD : GNT_WR;
    endfunction

endpackage

// File: rtl/ram16x2_rr_arb.sv
// -----------------------------------------------------------------------------
// ram16x2_rr_arb
//   Two-requester round-robin arbiter (write port vs read port) with a
//   registered priority pointer.
//   Ports:
//     CLK       in  clock, rising edge
//     LSRN      in  synchronous active-low reset (pointer -> GNT_WR)
//     en        in  arbitration enabled (RUN and no soft clear pending)
//     wr_valid  in  write request
//     rd_valid  in  read request
//     wr_ready  out write port may transfer this cycle
//     rd_ready  out read port may transfer this cycle
//   A port's ready depends only on en, the pointer and the *other* port's
//   valid, so there is no valid->ready loop through a requester. With both
//   valid exactly one ready is high; the pointer toggles only on such a
//   contested grant, so uncontested traffic never disturbs the fairness order.
// -----------------------------------------------------------------------------
module ram16x2_rr_arb
    import ram16x2_seq_pkg::*;
(
    input  logic CLK,
    input  logic LSRN,
    input  logic en,
    input  logic wr_valid,
    input  logic rd_valid,
    output logic wr_ready,
    output logic rd_ready
);

    gnt_e ptr;

    always_ff @(posedge CLK) begin
        if (!LSRN) begin
            ptr <= GNT_WR;
        end else if (en && wr_valid && rd_valid) begin
            ptr <= gnt_flip(ptr);
        end
    end

    always_comb begin
        wr_ready = 1'b0;
        rd_ready = 1'b0;
        if (en) begin
            wr_ready = (ptr == GNT_WR) || !rd_valid;
            rd_ready = (ptr == GNT_RD) || !wr_valid;
        end
    end

endmodule

// File: rtl/ram16x2_wr_seq.sv
// -----------------------------------------------------------------------------
// ram16x2_wr_seq
//   Upstream sequencer for a 16x2 single-port distributed-RAM slice. Merges a
//   write port and a read port onto the slice's shared AD/M/WE pins, sweeps
//   every location to INIT_VAL after reset, and registers the slice's
//   combinational read output onto RD_DATA one cycle after a read is issued.
//
//   Parameters:
//     INIT_VAL      value written to all 16 locations during a clear sweep
//     CLR_ON_RESET  1: sweep after reset; 0: go straight to RUN
//   Optional feature (macro RAM16X2_SEQ_CLR_EN):
//     adds CLR_REQ; a high CLR_REQ sampled in RUN starts a new sweep.
//
//   Ports:
//     CLK, LSRN                clock / synchronous active-low reset
//     WR_VALID/READY/ADDR/DATA write request channel
//     RD_VALID/READY/ADDR      read request channel
//     RD_DVAL, RD_DATA         read response (one-cycle pulse, data held)
//     AD, M, WE                registered RAM pins (WE drives the slice CE)
//     F                        RAM combinational read data
//     CLR_REQ                  soft clear request (RAM16X2_SEQ_CLR_EN only)
//     BUSY                     high while sweeping
// -----------------------------------------------------------------------------
module ram16x2_wr_seq
    import ram16x2_seq_pkg::*;
#(
    parameter logic [DATA_W-1:0] INIT_VAL     = 2'b00,
    parameter bit                CLR_ON_RESET = 1'b1
) (
    input  logic              CLK,
    input  logic              LSRN,
    input  logic              WR_VALID,
    output logic              WR_READY,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic [DATA_W-1:0] WR_DATA,
    input  logic              RD_VALID,
    output logic              RD_READY,
    input  logic [ADDR_W-1:0] RD_ADDR,
    output logic              RD_DVAL,
    output logic [DATA_W-1:0] RD_DATA,
    output logic [ADDR_W-1:0] AD,
    output logic [DATA_W-1:0] M,
    output logic              WE,
    input  logic [DATA_W-1:0] F,
`ifdef RAM16X2_SEQ_CLR_EN
    input  logic              CLR_REQ,
`endif
    output logic              BUSY
);

    // Read pipeline: bit 0 = address presented to slice, bit RD_STAGES = data captured.
    localparam int RD_STAGES = 1;

    state_e              state, state_nxt;
    logic [ADDR_W-1:0]   clr_cnt, clr_cnt_nxt;
    ram_req_t            ram_q, ram_nxt;
    logic [RD_STAGES:0]  vld_pipe;
    logic [DATA_W-1:0]   rd_data_q;
    logic                clr_req;
    logic                arb_en;
    logic                wr_acc, rd_acc;

    // Soft clear is only honoured in RUN; a request during a sweep is ignored.
`ifdef RAM16X2_SEQ_CLR_EN
    assign clr_req = CLR_REQ && (state == RUN);
`else
    assign clr_req = 1'b0;
`endif

    // Holding off both ports on the clear edge keeps the sweep from racing
    // with an accepted op on the shared pins.
    assign arb_en = (state == RUN) && !clr_req;

    ram16x2_rr_arb u_arb (
        .CLK      (CLK),
        .LSRN     (LSRN),
        .en       (arb_en),
        .wr_valid (WR_VALID),
        .rd_valid (RD_VALID),
        .wr_ready (WR_READY),
        .rd_ready (RD_READY)
    );

    assign wr_acc = WR_VALID && WR_READY;
    assign rd_acc = RD_VALID && RD_READY;

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        // Idle cycle: hold address/data, drop the write strobe.
        ram_nxt     = '{ad: ram_q.ad, m: ram_q.m, we: 1'b0};
        case (state)
            CLEAR: begin
                ram_nxt     = '{ad: clr_cnt, m: INIT_VAL, we: 1'b1};
                clr_cnt_nxt = clr_cnt + 1'b1;   // wraps 15 -> 0 ready for next sweep
                if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                end else if (wr_acc) begin
                    ram_nxt = '{ad: WR_ADDR, m: WR_DATA, we: 1'b1};
                end else if (rd_acc) begin
                    ram_nxt = '{ad: RD_ADDR, m: ram_q.m, we: 1'b0};
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!LSRN) begin
            state     <= CLR_ON_RESET ? CLEAR : RUN;
            clr_cnt   <= '0;
            ram_q     <= '0;
            vld_pipe  <= '0;   // drops any read in flight
            rd_data_q <= '0;
        end else begin
            state     <= state_nxt;
            clr_cnt   <= clr_cnt_nxt;
            ram_q     <= ram_nxt;
            vld_pipe  <= {vld_pipe[RD_STAGES-1:0], rd_acc};
            // F reflects AD set on the accept edge; a write issued the cycle
            // before lands on this same edge, so the new value is seen.
            if (vld_pipe[RD_STAGES-1]) begin
                rd_data_q <= F;
            end
        end
    end

    assign AD      = ram_q.ad;
    assign M       = ram_q.m;
    assign WE      = ram_q.we;
    assign RD_DVAL = vld_pipe[RD_STAGES];
    assign RD_DATA = rd_data_q;
    assign BUSY    = (state == CLEAR);

endmodule
